// File: rtl/spi_slave_multi.sv
// Multi-channel SPI mode-0 slave: per-channel PWM setpoint writes and QD count reads,
// all logic in the CLK domain with synchronised, oversampled SPI pins.
module spi_slave_multi #(
   parameter int N_CHANNELS     = 4,
   parameter int PWM_DATA_WIDTH = 16,
   parameter int QD_DATA_WIDTH  = 16,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                                CLK,
   input  logic                                RST_N,
   input  logic                                SPI_CLK,
   input  logic                                SPI_CS,
   input  logic                                SPI_MOSI,
   output logic                                SPI_MISO,
   input  logic [N_CHANNELS*QD_DATA_WIDTH-1:0] QD_COUNT,
   output logic [N_CHANNELS*PWM_DATA_WIDTH-1:0] PWM_OUT,
   output logic [N_CHANNELS-1:0]               PWM_UPDATE,
   output logic                                SOFT_RST,
   output logic                                LED,
   output logic                                ERR
);

   localparam int PB   = (PWM_DATA_WIDTH + 7) / 8;
   localparam int QB   = (QD_DATA_WIDTH + 7) / 8;
   localparam int RXW  = PB * 8;
   localparam int TXW  = QB * 8;
   localparam int MAXB = (RXW > TXW) ? RXW : TXW;
   localparam int CW   = $clog2(MAXB + 1);

   typedef enum logic [2:0] {IDLE, CMD, RX, TX, DISCARD} state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   logic [CW-1:0]      cnt;
   logic [6:0]         cmd_sr;
   logic [7:0]         cmd_byte;
   logic [3:0]         op, ch_in, ch_q;
   logic               ch_ok;
   logic [RXW-2:0]     rx_sr;
   logic [RXW-1:0]     rx_next;
   logic [TXW-1:0]     tx_sr, snap;
   logic [PWM_DATA_WIDTH-1:0] pwm [N_CHANNELS];

   logic cmd_done, do_rst, do_led, do_err, do_snap, do_wr;

   // CS chain resets low so a CS already held low at reset release is not seen as a new frame
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   assign cmd_byte = {cmd_sr, mosi_s};
   assign op       = cmd_byte[7:4];
   assign ch_in    = cmd_byte[3:0];
   assign ch_ok    = int'(ch_in) < N_CHANNELS;
   assign cmd_done = (state == CMD) && sclk_rise && (cnt == CW'(7));
   assign rx_next  = {rx_sr, mosi_s};

   always_comb begin
      snap = '0;
      for (int unsigned k = 0; k < N_CHANNELS; k++)
         if (ch_in == 4'(k))
            snap[QD_DATA_WIDTH-1:0] = QD_COUNT[k*QD_DATA_WIDTH +: QD_DATA_WIDTH];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_n;
   end

   // A completed 0xFF byte still executes when CS rises in the same cycle
   always_comb begin
      state_n = state;
      do_rst  = 1'b0;
      do_led  = 1'b0;
      do_err  = 1'b0;
      do_snap = 1'b0;
      do_wr   = 1'b0;
      case (state)
         IDLE: if (cs_fall) state_n = CMD;
         CMD: begin
            if (cmd_done) begin
               if (cmd_byte == 8'hFF) begin
                  do_rst  = 1'b1;
                  state_n = DISCARD;
               end else if (!cs_rise) begin
                  if (op == 4'h3 && ch_ok) begin
                     do_led  = 1'b1;
                     state_n = DISCARD;
                  end else if (op == 4'h1 && ch_ok) begin
                     state_n = RX;
                  end else if (op == 4'h2 && ch_ok) begin
                     do_snap = 1'b1;
                     state_n = TX;
                  end else begin
                     do_err  = 1'b1;
                     state_n = DISCARD;
                  end
               end
            end
         end
         RX: begin
            if (sclk_rise && cnt == CW'(RXW - 1)) begin
               do_wr   = ~cs_rise;
               state_n = DISCARD;
            end
         end
         TX: if (sclk_rise && cnt == CW'(TXW - 1)) state_n = DISCARD;
         DISCARD: ;
         default: state_n = IDLE;
      endcase
      if (cs_rise) state_n = IDLE;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt        <= '0;
         cmd_sr     <= '0;
         ch_q       <= '0;
         rx_sr      <= '0;
         tx_sr      <= '0;
         SPI_MISO   <= 1'b0;
         PWM_UPDATE <= '0;
         SOFT_RST   <= 1'b0;
         LED        <= 1'b1;
         ERR        <= 1'b0;
         for (int unsigned k = 0; k < N_CHANNELS; k++) pwm[k] <= '0;
      end else begin
         if (state_n != state)
            cnt <= '0;
         else if (sclk_rise && (state == CMD || state == RX || state == TX))
            cnt <= cnt + 1'b1;

         if (state == CMD && sclk_rise) cmd_sr <= cmd_byte[6:0];
         if (cmd_done) ch_q <= ch_in;
         if (state == RX && sclk_rise) rx_sr <= rx_next[RXW-2:0];

         if (do_snap)
            tx_sr <= snap;
         else if (state == TX && sclk_fall)
            tx_sr <= {tx_sr[TXW-2:0], 1'b0};

         // Last bit is held until the rising edge that consumes it
         if (state_n != TX)
            SPI_MISO <= 1'b0;
         else if (state == TX && sclk_fall)
            SPI_MISO <= tx_sr[TXW-1];

         for (int unsigned k = 0; k < N_CHANNELS; k++) begin
            PWM_UPDATE[k] <= do_wr && (ch_q == 4'(k));
            if (do_rst)
               pwm[k] <= '0;
            else if (do_wr && ch_q == 4'(k))
               pwm[k] <= rx_next[PWM_DATA_WIDTH-1:0];
         end

         SOFT_RST <= do_rst;
         if (do_led) LED <= ~LED;
         if (do_rst)      ERR <= 1'b0;
         else if (do_err) ERR <= 1'b1;
      end
   end

   always_comb begin
      PWM_OUT = '0;
      for (int unsigned k = 0; k < N_CHANNELS; k++)
         PWM_OUT[k*PWM_DATA_WIDTH +: PWM_DATA_WIDTH] = pwm[k];
   end

endmodule

// File: tb/tb_spi_slave_multi.sv
// Directed plus randomized frames against a frame-level reference model of the SPI slave.
`timescale 1ns/1ps
module tb_spi_slave_multi;

   localparam int N    = 4;
   localparam int W    = 16;
   localparam int QW   = 16;
   localparam int HALF = 60;

   logic CLK = 1'b0;
   logic RST_N, SPI_CLK, SPI_CS, SPI_MOSI, SPI_MISO;
   logic [N*QW-1:0] QD_COUNT;
   logic [N*W-1:0]  PWM_OUT;
   logic [N-1:0]    PWM_UPDATE;
   logic SOFT_RST, LED, ERR;

   spi_slave_multi #(
      .N_CHANNELS(N), .PWM_DATA_WIDTH(W), .QD_DATA_WIDTH(QW), .SYNC_STAGES(2)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS),
      .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .QD_COUNT(QD_COUNT),
      .PWM_OUT(PWM_OUT), .PWM_UPDATE(PWM_UPDATE), .SOFT_RST(SOFT_RST),
      .LED(LED), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   logic [W-1:0]  m_pwm [N];
   logic [QW-1:0] m_qd  [N];
   logic          m_led, m_err;
   int            exp_upd [N];
   int            exp_soft;
   int            upd_cnt [N];
   int            soft_cnt;

   byte unsigned  tq[$];
   logic          rxbits[$];
   int            qd_chg_bit = -1;
   int            qd_chg_ch  = 0;
   logic [QW-1:0] qd_chg_val;

   always @(negedge CLK) begin
      if (RST_N) begin
         for (int k = 0; k < N; k++) if (PWM_UPDATE[k]) upd_cnt[k]++;
         if (SOFT_RST) soft_cnt++;
      end
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_qd();
      for (int k = 0; k < N; k++) QD_COUNT[k*QW +: QW] = m_qd[k];
   endtask

   task automatic clear_counts();
      for (int k = 0; k < N; k++) begin
         upd_cnt[k] = 0;
         exp_upd[k] = 0;
      end
      soft_cnt = 0;
      exp_soft = 0;
   endtask

   task automatic spi_bits(input int nbits);
      byte unsigned b;
      SPI_CS = 1'b0;
      #(HALF);
      for (int i = 0; i < nbits; i++) begin
         if (i == qd_chg_bit) QD_COUNT[qd_chg_ch*QW +: QW] = qd_chg_val;
         b = tq[i/8];
         SPI_MOSI = b[7 - (i % 8)];
         #(HALF);
         rxbits.push_back(SPI_MISO);
         SPI_CLK = 1'b1;
         #(HALF);
         SPI_CLK = 1'b0;
      end
      #(HALF);
   endtask

   task automatic cs_release();
      SPI_CS   = 1'b1;
      SPI_MOSI = 1'b0;
      repeat (8) @(posedge CLK);
      #1;
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("%s pwm%0d", tag, k), 64'(PWM_OUT[k*W +: W]), 64'(m_pwm[k]));
         chk($sformatf("%s upd%0d", tag, k), 64'(upd_cnt[k]), 64'(exp_upd[k]));
      end
      chk({tag, " led"}, 64'(LED), 64'(m_led));
      chk({tag, " err"}, 64'(ERR), 64'(m_err));
      chk({tag, " soft"}, 64'(soft_cnt), 64'(exp_soft));
      chk({tag, " miso_idle"}, 64'(SPI_MISO), 64'd0);
   endtask

   // Applies one CS frame of nbits to the model and checks DUT state and MISO stream
   task automatic run_frame(input int nbits, input string tag);
      byte unsigned c;
      logic [3:0] op, ch;
      logic [QW-1:0] resp;
      logic [63:0] obs_s, exp_s;
      bit is_get;
      int nb;
      c = tq[0];
      op = c[7:4];
      ch = c[3:0];
      resp = (int'(ch) < N) ? m_qd[ch] : '0;
      is_get = 1'b0;
      rxbits.delete();
      spi_bits(nbits);
      cs_release();
      nb = nbits / 8;
      if (nb >= 1) begin
         if (c == 8'hFF) begin
            for (int k = 0; k < N; k++) m_pwm[k] = '0;
            m_err = 1'b0;
            exp_soft++;
         end else if (int'(ch) < N) begin
            case (op)
               4'h1: if (nb >= 3) begin
                  m_pwm[ch] = {tq[1], tq[2]};
                  exp_upd[ch]++;
               end
               4'h2: is_get = 1'b1;
               4'h3: m_led = ~m_led;
               default: m_err = 1'b1;
            endcase
         end else begin
            m_err = 1'b1;
         end
      end
      obs_s = '0;
      exp_s = '0;
      for (int i = 0; i < rxbits.size() && i < 64; i++) begin
         obs_s[i] = rxbits[i];
         exp_s[i] = (is_get && i >= 8 && i < 8 + QW) ? resp[QW - 1 - (i - 8)] : 1'b0;
      end
      chk({tag, " miso_stream"}, obs_s, exp_s);
      if (qd_chg_bit >= 0) begin
         m_qd[qd_chg_ch] = qd_chg_val;
         qd_chg_bit = -1;
      end
      check_all(tag);
   endtask

   initial begin
      int sel, nbits;
      logic [3:0] ch, op;
      RST_N = 1'b0;
      SPI_CLK = 1'b0;
      SPI_CS = 1'b1;
      SPI_MOSI = 1'b0;
      for (int k = 0; k < N; k++) begin
         m_pwm[k] = '0;
         m_qd[k] = '0;
      end
      m_led = 1'b1;
      m_err = 1'b0;
      clear_counts();
      drive_qd();
      #37;
      RST_N = 1'b1;
      repeat (6) @(posedge CLK);
      #1;
      check_all("reset");
      chk("reset pwm_update", 64'(PWM_UPDATE), 64'd0);

      tq = '{8'h12, 8'hAB, 8'hCD};
      run_frame(24, "set_ch2");

      m_qd[1] = 16'h1234;
      m_qd[3] = 16'h5A5A;
      drive_qd();
      qd_chg_bit = 12;
      qd_chg_ch = 1;
      qd_chg_val = 16'hFFFF;
      tq = '{8'h21, 8'h00, 8'h00};
      run_frame(24, "get_ch1");

      tq = '{8'h15, 8'h00, 8'h00};
      run_frame(24, "bad_ch");
      tq = '{8'hFF};
      run_frame(8, "reset_cmd");

      tq = '{8'h10, 8'h11, 8'h22};
      run_frame(24, "set_ch0");
      tq = '{8'h10, 8'hAA};
      run_frame(16, "partial_set");
      tq = '{8'h10, 8'h00, 8'h42};
      run_frame(24, "set_ch0_42");

      tq = '{8'h30};
      run_frame(8, "led1");
      tq = '{8'h30};
      run_frame(8, "led2");
      tq = '{8'h30, 8'h30};
      run_frame(16, "led_once");

      tq = '{8'h23, 8'h00, 8'h00, 8'h00};
      run_frame(32, "get_extra");

      tq = '{8'h11, 8'h55, 8'h66};
      spi_bits(20);
      RST_N = 1'b0;
      #25;
      chk("rst_mid pwm", 64'(PWM_OUT), 64'd0);
      chk("rst_mid update", 64'(PWM_UPDATE), 64'd0);
      chk("rst_mid soft", 64'(SOFT_RST), 64'd0);
      chk("rst_mid led", 64'(LED), 64'd1);
      chk("rst_mid err", 64'(ERR), 64'd0);
      chk("rst_mid miso", 64'(SPI_MISO), 64'd0);
      RST_N = 1'b1;
      for (int k = 0; k < N; k++) m_pwm[k] = '0;
      m_led = 1'b1;
      m_err = 1'b0;
      clear_counts();
      tq = '{8'h6A, 8'h12, 8'h34};
      spi_bits(24);
      cs_release();
      check_all("after_rst");
      tq = '{8'h12, 8'hBE, 8'hEF};
      run_frame(24, "fresh_set");

      for (int f = 0; f < 40; f++) begin
         sel = $urandom_range(0, 5);
         ch  = 4'($urandom_range(0, 5));
         tq.delete();
         case (sel)
            0, 1: begin
               tq.push_back({4'h1, ch});
               tq.push_back(8'($urandom));
               tq.push_back(8'($urandom));
            end
            2: begin
               for (int k = 0; k < N; k++) m_qd[k] = 16'($urandom);
               drive_qd();
               if ($urandom_range(0, 1) == 1 && int'(ch) < N) begin
                  qd_chg_bit = $urandom_range(10, 20);
                  qd_chg_ch = int'(ch);
                  qd_chg_val = 16'($urandom);
               end
               tq.push_back({4'h2, ch});
               tq.push_back(8'($urandom));
               tq.push_back(8'($urandom));
            end
            3: tq.push_back({4'h3, ch});
            4: begin
               op = 4'($urandom_range(4, 14));
               tq.push_back({op, ch});
            end
            default: tq.push_back(8'hFF);
         endcase
         if ($urandom_range(0, 3) == 0) tq.push_back(8'($urandom));
         nbits = tq.size() * 8;
         if ($urandom_range(0, 4) == 0) nbits = $urandom_range(1, nbits - 1);
         if (qd_chg_bit >= nbits) qd_chg_bit = -1;
         run_frame(nbits, $sformatf("rand%0d", f));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
